// File: rtl/clock_divider_gen_pkg.sv
// Shared constants for the CPU clock-select path: frequencies, divide ratios and strobe bit indices.
// Consumers such as the clock multiplexer import this package to agree on the stb bit layout.
package clock_divider_gen_pkg;

  localparam int PLL_HZ         = 100_000_000;
  localparam int BASE_HZ        = 4_000_000;
  localparam int PRESCALE_DEF   = PLL_HZ / BASE_HZ;
  localparam int HZ250_HALF_DEF = 8000;
  localparam int HB_HALF_DEF    = 125;

  localparam int PRE_W     = 5;
  localparam int DIV_W     = 14;
  localparam int HB_W      = 7;
  localparam int STB_W     = 4;
  localparam int KHZ31_BIT = 6;

  localparam int STB_MHZ2  = 0;
  localparam int STB_MHZ1  = 1;
  localparam int STB_KHZ31 = 2;
  localparam int STB_HZ250 = 3;

  function automatic logic rose(input logic prev, input logic nxt);
    return nxt & ~prev;
  endfunction

endpackage

// File: rtl/clock_divider_gen_if.sv
// Run control plus the derived clocks, strobes and heartbeat of clock_divider_gen.
interface clock_divider_gen_if;
  import clock_divider_gen_pkg::*;

  logic             run;
  logic             MHz2;
  logic             MHz1;
  logic             KHz31;
  logic             Hz250;
  logic [STB_W-1:0] stb;
  logic             heartbeat;

  modport master (input run, output MHz2, output MHz1, output KHz31, output Hz250,
                  output stb, output heartbeat);
  modport slave  (output run, input MHz2, input MHz1, input KHz31, input Hz250,
                  input stb, input heartbeat);
endinterface

// File: rtl/clock_divider_gen_clk_prescaler.sv
// Divides the 100MHz pll clock down to a one-cycle 4MHz base tick, frozen while run is low.
module clk_prescaler
  import clock_divider_gen_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_r;

  // prescale counter, wraps at PRESCALE-1 and holds while run is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= {PRE_W{1'b0}};
    end else if (run) begin
      if (pre_r == PRE_LAST) begin
        pre_r <= {PRE_W{1'b0}};
      end else begin
        pre_r <= pre_r + PRE_W'(1);
      end
    end else begin
      pre_r <= pre_r;
    end
  end

  assign tick = run && (pre_r == PRE_LAST);

endmodule

// File: rtl/clock_divider_gen.sv
// Derives phase-aligned 2MHz/1MHz/31.25kHz/250Hz clocks plus rising-edge strobes from pll0_100MHz.
// Build option: define HEARTBEAT_EN for the 1Hz heartbeat output; otherwise heartbeat is tied 0.
module clock_divider_gen
  import clock_divider_gen_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int HZ250_HALF = HZ250_HALF_DEF,
  parameter int HB_HALF    = HB_HALF_DEF
) (
  input logic                 pll0_100MHz,
  input logic                 n_reset,
  clock_divider_gen_if.master bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HZ250_HALF - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HZ250_HALF);

  logic             tick_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             hz250_r;
  logic             hz250_nxt_s;
  logic [STB_W-1:0] stb_r;
  logic [STB_W-1:0] stb_nxt_s;

  clk_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (pll0_100MHz),
    .rst_n (n_reset),
    .run   (bus.run),
    .tick  (tick_s)
  );

  // div steps down through 0..DIV_LAST so every output bit rises on a borrow,
  // which lines up all rising edges with the 0 -> DIV_LAST wrap
  always_comb begin
    div_nxt_s   = div_r;
    hz250_nxt_s = hz250_r;
    stb_nxt_s   = {STB_W{1'b0}};
    if (tick_s) begin
      if (div_r == {DIV_W{1'b0}}) begin
        div_nxt_s = DIV_LAST;
      end else begin
        div_nxt_s = div_r - DIV_W'(1);
      end
      if ((div_r == {DIV_W{1'b0}}) || (div_r == DIV_HALF)) begin
        hz250_nxt_s = ~hz250_r;
      end else begin
        hz250_nxt_s = hz250_r;
      end
      stb_nxt_s[STB_MHZ2]  = rose(div_r[0], div_nxt_s[0]);
      stb_nxt_s[STB_MHZ1]  = rose(div_r[1], div_nxt_s[1]);
      stb_nxt_s[STB_KHZ31] = rose(div_r[KHZ31_BIT], div_nxt_s[KHZ31_BIT]);
      stb_nxt_s[STB_HZ250] = rose(hz250_r, hz250_nxt_s);
    end else begin
      div_nxt_s   = div_r;
      hz250_nxt_s = hz250_r;
      stb_nxt_s   = {STB_W{1'b0}};
    end
  end

  // divider chain, Hz250 flop and strobe register
  always_ff @(posedge pll0_100MHz or negedge n_reset) begin
    if (!n_reset) begin
      div_r   <= {DIV_W{1'b0}};
      hz250_r <= 1'b0;
      stb_r   <= {STB_W{1'b0}};
    end else begin
      div_r   <= div_nxt_s;
      hz250_r <= hz250_nxt_s;
      stb_r   <= stb_nxt_s;
    end
  end

  assign bus.MHz2  = div_r[0];
  assign bus.MHz1  = div_r[1];
  assign bus.KHz31 = div_r[KHZ31_BIT];
  assign bus.Hz250 = hz250_r;
  assign bus.stb   = stb_r;

`ifdef HEARTBEAT_EN
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);

  logic [HB_W-1:0] hb_cnt_r;
  logic            hb_r;

  // counts Hz250 strobes and toggles heartbeat every HB_HALF of them
  always_ff @(posedge pll0_100MHz or negedge n_reset) begin
    if (!n_reset) begin
      hb_cnt_r <= {HB_W{1'b0}};
      hb_r     <= 1'b0;
    end else if (stb_r[STB_HZ250]) begin
      if (hb_cnt_r == HB_LAST) begin
        hb_cnt_r <= {HB_W{1'b0}};
        hb_r     <= ~hb_r;
      end else begin
        hb_cnt_r <= hb_cnt_r + HB_W'(1);
        hb_r     <= hb_r;
      end
    end else begin
      hb_cnt_r <= hb_cnt_r;
      hb_r     <= hb_r;
    end
  end

  assign bus.heartbeat = hb_r;
`else
  assign bus.heartbeat = 1'b0;
`endif

endmodule
